// File: rtl/dual_demux_sched_pkg.sv
// rtl/dual_demux_sched_pkg.sv - shared encodings and helpers for the dual_demux sequencer
// Purpose: FSM state encoding, demux destination select codes, arbitration modes and
//          the transaction counter width helper used by dual_demux_sched and rr_arb2.
// Ports:   none (package)
package dual_demux_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_ACK    = 2'd3
   } state_t;

   localparam logic SEL_DEST_A = 1'b0;
   localparam logic SEL_DEST_B = 1'b1;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   // Counter must hold the larger of the two phase lengths.
   function automatic int cnt_width(input int setup_cycles, input int hold_cycles);
      int m;
      m = (setup_cycles > hold_cycles) ? setup_cycles : hold_cycles;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dual_demux_sched_if.sv
// rtl/dual_demux_sched_if.sv - requester and demux-side signal bundle for dual_demux_sched
// Purpose: groups the two four-phase requesters and the dual_demux drive signals.
// Ports:   req_a/data_a, req_b/data_b (requesters), ack_a/ack_b (acknowledges),
//          sel/y0/y1 (demux drive), wr_en (bank strobe), busy (sequencer not idle).
//          master = requester/datapath side, slave = sequencer.
interface dual_demux_sched_if;

   logic       req_a;
   logic [1:0] data_a;
   logic       req_b;
   logic [1:0] data_b;
   logic       ack_a;
   logic       ack_b;
   logic       sel;
   logic       y0;
   logic       y1;
   logic       wr_en;
   logic       busy;

   modport master (
      output req_a, data_a, req_b, data_b,
      input  ack_a, ack_b, sel, y0, y1, wr_en, busy
   );

   modport slave (
      input  req_a, data_a, req_b, data_b,
      output ack_a, ack_b, sel, y0, y1, wr_en, busy
   );

endinterface

// File: rtl/dual_demux_sched_rr_arb2.sv
// rtl/dual_demux_sched_rr_arb2.sv - two-input arbiter with last-grant memory
// Purpose: picks requester A or B; ties go round-robin (ARB_RR) or always to A (ARB_FIXED).
// Ports:   clk, rst (async active-high), req_a, req_b, take (commit the grant this edge),
//          gnt_valid (some request present), gnt_b (1 = B wins, 0 = A wins).
module rr_arb2
   import dual_demux_sched_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR
) (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic take,
   output logic gnt_valid,
   output logic gnt_b
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      gnt_valid = req_a | req_b;
      // Only a tie consults history; a lone request always wins.
      if (req_a && req_b) begin
         gnt_b = (ARB_MODE == ARB_FIXED) ? SEL_DEST_A : (last_grant_q == SEL_DEST_A);
      end else begin
         gnt_b = req_b;
      end
      last_grant_d = last_grant_q;
      if (take && gnt_valid) begin
         last_grant_d = gnt_b;
      end
   end

   // Reset to B so that A wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= SEL_DEST_B;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/dual_demux_sched.sv
// rtl/dual_demux_sched.sv - grant/settle/strobe/ack sequencer in front of dual_demux
// Purpose: grants one requester at a time, drives sel/y0/y1, waits SETUP_CYCLES, strobes
//          wr_en for HOLD_CYCLES, then holds ack until the granted req drops.
// Ports:   clk, rst (async active-high), bus (dual_demux_sched_if.slave: req/data in,
//          ack_a/ack_b, sel, y0, y1, wr_en, busy out). All outputs are registered.
module dual_demux_sched
   import dual_demux_sched_pkg::*;
#(
   parameter int SETUP_CYCLES = 1,
   parameter int HOLD_CYCLES  = 2,
   parameter int ARB_MODE     = ARB_RR
) (
   input logic               clk,
   input logic               rst,
   dual_demux_sched_if.slave bus
);

   localparam int            CW         = cnt_width(SETUP_CYCLES, HOLD_CYCLES);
   localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic [1:0]    y_q, y_d;
   logic          wr_en_q, wr_en_d;
   logic          ack_a_q, ack_a_d;
   logic          ack_b_q, ack_b_d;
   logic          busy_q, busy_d;

   logic          gnt_valid;
   logic          gnt_b;
   logic          granted_req;

   rr_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_a     (bus.req_a),
      .req_b     (bus.req_b),
      .take      (state_q == ST_IDLE),
      .gnt_valid (gnt_valid),
      .gnt_b     (gnt_b)
   );

   // sel_q doubles as the record of which side owns the current transaction.
   assign granted_req = (sel_q == SEL_DEST_B) ? bus.req_b : bus.req_a;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= SEL_DEST_A;
         y_q     <= 2'b00;
         wr_en_q <= 1'b0;
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         y_q     <= y_d;
         wr_en_q <= wr_en_d;
         ack_a_q <= ack_a_d;
         ack_b_q <= ack_b_d;
         busy_q  <= busy_d;
      end
   end

   // Counter is reloaded on every phase entry and counts down to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               if (SETUP_CYCLES == 0) begin
                  state_d = ST_STROBE;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LOAD;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = HOLD_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_ACK: begin
            if (!granted_req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so that every output is a flop
   // and changes on the same edge as the state it belongs to.
   always_comb begin
      sel_d = sel_q;
      y_d   = y_q;
      if ((state_q == ST_IDLE) && gnt_valid) begin
         sel_d = gnt_b;
         y_d   = gnt_b ? bus.data_b : bus.data_a;
      end
      wr_en_d = (state_d == ST_STROBE);
      busy_d  = (state_d != ST_IDLE);
      ack_a_d = (state_d == ST_ACK) && (sel_d == SEL_DEST_A);
      ack_b_d = (state_d == ST_ACK) && (sel_d == SEL_DEST_B);
   end

   assign bus.sel   = sel_q;
   assign bus.y0    = y_q[0];
   assign bus.y1    = y_q[1];
   assign bus.wr_en = wr_en_q;
   assign bus.ack_a = ack_a_q;
   assign bus.ack_b = ack_b_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dual_demux_sched.sv
// tb/tb_dual_demux_sched.sv - scoreboard bench for dual_demux_sched over three parameter sets
module tb_dual_demux_sched;
   import dual_demux_sched_pkg::*;

   localparam int NCFG       = 3;
   localparam int RUN_CYCLES = 3000;

   typedef struct {
      int side;
      int data;
      int start;
   } wr_exp_t;

   typedef struct {
      int side;
      int start;
      int stop;
   } ack_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   run = 1'b0;
   bit   chk_en = 1'b0;
   bit   dir_req = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   event rchk_ev;
   event final_ev;

   always #5 clk = ~clk;

   task automatic chk(input int cfg, input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL cfg%0d %s: got %0d expected %0d (t=%0t)", cfg, nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int S = (g == 0) ? 1 : (g == 1) ? 0 : 2;
      localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 3;
      localparam int M = (g == 1) ? ARB_FIXED : ARB_RR;

      dual_demux_sched_if bus ();

      dual_demux_sched #(
         .SETUP_CYCLES (S),
         .HOLD_CYCLES  (H),
         .ARB_MODE     (M)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      logic [6:0] outs;
      assign outs = {bus.sel, bus.y1, bus.y0, bus.wr_en, bus.ack_a, bus.ack_b, bus.busy};

      // Requesters: raise req with random payload, optionally drop after one cycle,
      // otherwise hold (payload wandering) until ack, then drop after 0..2 cycles.
      logic [1:0] rq = 2'b00;
      logic [1:0] dq [2] = '{2'b00, 2'b00};
      int         ph [2] = '{0, 0};
      int         cnt [2] = '{0, 0};
      int         age [2] = '{0, 0};
      bit         early [2] = '{1'b0, 1'b0};

      assign bus.req_a  = rq[0];
      assign bus.req_b  = rq[1];
      assign bus.data_a = dq[0];
      assign bus.data_b = dq[1];

      always @(negedge clk) begin
         for (int s = 0; s < 2; s++) begin
            logic ack_s;
            ack_s = (s == 0) ? bus.ack_a : bus.ack_b;
            if (!run) begin
               ph[s]  = 0;
               cnt[s] = $urandom_range(3, 0);
               rq[s]  = (s == 0) ? dir_req : 1'b0;
               dq[s]  = (s == 0) ? 2'b10 : 2'b00;
            end else begin
               case (ph[s])
                  0: begin
                     if (cnt[s] == 0) begin
                        rq[s]    = 1'b1;
                        dq[s]    = 2'($urandom);
                        early[s] = ($urandom_range(7, 0) == 0);
                        age[s]   = 0;
                        ph[s]    = 1;
                     end else begin
                        cnt[s]--;
                     end
                  end
                  1: begin
                     age[s]++;
                     if (ack_s) begin
                        cnt[s] = $urandom_range(2, 0);
                        ph[s]  = 2;
                        if (cnt[s] == 0) begin
                           rq[s]  = 1'b0;
                           ph[s]  = 0;
                           cnt[s] = $urandom_range(3, 0);
                        end
                     end else if (early[s] && age[s] >= 1) begin
                        rq[s]  = 1'b0;
                        ph[s]  = 0;
                        cnt[s] = $urandom_range(6, 2);
                     end else if ($urandom_range(3, 0) == 0) begin
                        dq[s] = 2'($urandom);
                     end
                  end
                  default: begin
                     cnt[s]--;
                     if (cnt[s] <= 0) begin
                        rq[s]  = 1'b0;
                        ph[s]  = 0;
                        cnt[s] = $urandom_range(3, 0);
                     end
                  end
               endcase
            end
         end
      end

      // Reference model: a timeline per transaction. Grant at edge t0 when idle;
      // strobe occupies edges t0+S .. t0+S+H-1; ack from edge t0+S+H until the
      // first later edge that samples the owner's req low.
      int         m_edge = 0;
      bit         m_busy = 1'b0;
      bit         m_last = 1'b1;
      bit         m_side = 1'b0;
      logic [2:0] m_sel_y = 3'b000;
      int         m_t0 = 0;
      int         n_trans = 0;
      wr_exp_t    wr_q [$];
      ack_exp_t   ack_q [$];

      always @(posedge clk) begin
         m_edge++;
         if (rst) begin
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_sel_y = 3'b000;
            wr_q.delete();
            ack_q.delete();
         end else if (chk_en) begin
            if (!m_busy) begin
               if (bus.req_a || bus.req_b) begin
                  if (bus.req_a && bus.req_b) begin
                     m_side = (M == ARB_FIXED) ? 1'b0 : !m_last;
                  end else begin
                     m_side = bus.req_b;
                  end
                  m_last  = m_side;
                  m_busy  = 1'b1;
                  m_t0    = m_edge;
                  m_sel_y = {m_side, (m_side ? bus.data_b : bus.data_a)};
                  wr_q.push_back('{side: int'(m_side), data: int'(m_sel_y[1:0]), start: m_edge + S});
                  n_trans++;
               end
            end else if ((m_edge > m_t0 + S + H) && !(m_side ? bus.req_b : bus.req_a)) begin
               m_busy = 1'b0;
               ack_q.push_back('{side: int'(m_side), start: m_t0 + S + H, stop: m_edge});
            end
         end
      end

      // Monitor: pops expectations when the DUT shows a strobe or completes an ack.
      bit       wr_prev = 1'b0;
      bit       ack_prev = 1'b0;
      int       wr_len = 0;
      int       ack_start = 0;
      int       ack_side = 0;
      wr_exp_t  we;
      ack_exp_t ae;

      always @(negedge clk) begin
         if (rst || !chk_en) begin
            wr_prev  = 1'b0;
            ack_prev = 1'b0;
            wr_len   = 0;
         end else begin
            chk(g, "ack_onehot", int'(bus.ack_a & bus.ack_b), 0);
            chk(g, "wr_ack_overlap", int'(bus.wr_en & (bus.ack_a | bus.ack_b)), 0);
            chk(g, "busy", int'(bus.busy), int'(m_busy));
            chk(g, "sel_y", int'({bus.sel, bus.y1, bus.y0}), int'(m_sel_y));
            if (bus.wr_en && !wr_prev) begin
               wr_len = 0;
               if (wr_q.size() == 0) begin
                  chk(g, "wr_unexpected", 1, 0);
               end else begin
                  we = wr_q.pop_front();
                  chk(g, "wr_start_edge", m_edge, we.start);
                  chk(g, "wr_payload", int'({bus.sel, bus.y1, bus.y0}), we.side * 4 + we.data);
               end
            end
            if (bus.wr_en) wr_len++;
            if (!bus.wr_en && wr_prev) chk(g, "wr_len", wr_len, H);
            if ((bus.ack_a | bus.ack_b) && !ack_prev) begin
               ack_start = m_edge;
               ack_side  = int'(bus.ack_b);
            end
            if (!(bus.ack_a | bus.ack_b) && ack_prev) begin
               if (ack_q.size() == 0) begin
                  chk(g, "ack_unexpected", 1, 0);
               end else begin
                  ae = ack_q.pop_front();
                  chk(g, "ack_side", ack_side, ae.side);
                  chk(g, "ack_start_edge", ack_start, ae.start);
                  chk(g, "ack_stop_edge", m_edge, ae.stop);
               end
            end
            wr_prev  = bus.wr_en;
            ack_prev = bus.ack_a | bus.ack_b;
         end
      end

      always @(rchk_ev) begin
         chk(g, "rst_outputs", int'(outs), 0);
      end

      always @(final_ev) begin
         chk(g, "drain_busy", int'(bus.busy), 0);
         chk(g, "wr_q_left", wr_q.size(), 0);
         chk(g, "ack_q_left", ack_q.size(), 0);
         chk(g, "enough_trans", int'(n_trans >= 50), 1);
      end
   end

   initial begin
      int i;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      -> rchk_ev;
      #1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      dir_req = 1'b1;
      i = 0;
      while (!g_cfg[0].bus.wr_en && i < 30) begin
         @(negedge clk);
         i++;
      end
      chk(0, "reach_strobe", int'(g_cfg[0].bus.wr_en), 1);
      #2 rst = 1'b1;
      #1 -> rchk_ev;
      #1;
      dir_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      run    = 1'b1;
      repeat (RUN_CYCLES) @(negedge clk);
      run = 1'b0;
      i = 0;
      while ((g_cfg[0].m_busy || g_cfg[1].m_busy || g_cfg[2].m_busy ||
              g_cfg[0].bus.busy || g_cfg[1].bus.busy || g_cfg[2].bus.busy) && i < 200) begin
         @(negedge clk);
         i++;
      end
      repeat (3) @(negedge clk);
      -> final_ev;
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
